// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: issues eight sequential word reads for a missed line,
// writes each returned word into the data array, then pulses a tag-array write.
module cache_fill_ctrl #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [WORDS-1:0]  word_enable,
    output logic [15:0]       data_array_din,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_address
);

    localparam int unsigned CNT_W = 4;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_req_cnt, w_req_cnt_nxt;
    logic [CNT_W-1:0]  r_ret_cnt, w_ret_cnt_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic              w_req_active;
    logic              w_wr;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_req_cnt <= '0;
            r_ret_cnt <= '0;
            r_base    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_cnt <= w_req_cnt_nxt;
            r_ret_cnt <= w_ret_cnt_nxt;
            r_base    <= w_base_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_req_cnt_nxt = r_req_cnt;
        w_ret_cnt_nxt = r_ret_cnt;
        w_base_nxt    = r_base;
        w_req_active  = 1'b0;
        w_wr          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (miss_detected) begin
                    w_base_nxt    = miss_address & LINE_MASK;
                    w_req_cnt_nxt = '0;
                    w_ret_cnt_nxt = '0;
                    w_state_nxt   = S_FILL;
                end
            end
            S_FILL: begin
                w_req_active = (r_req_cnt < CNT_FULL);
                if (w_req_active) begin
                    w_req_cnt_nxt = r_req_cnt + CNT_W'(1);
                end
                // Requests and returns are independent; both may advance in one cycle.
                if (memory_data_valid) begin
                    w_wr          = 1'b1;
                    w_ret_cnt_nxt = r_ret_cnt + CNT_W'(1);
                    if (r_ret_cnt == CNT_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        fsm_busy         = (r_state != S_IDLE);
        mem_enable       = w_req_active;
        memory_address   = w_req_active ? (r_base + ADDR_W'({r_req_cnt, 1'b0})) : r_base;
        write_data_array = w_wr;
        word_enable      = w_wr ? (WORDS'(1) << r_ret_cnt) : '0;
        data_array_din   = memory_data;
        write_tag_array  = (r_state == S_DONE);
        fill_address     = r_base;
    end

endmodule
